// File: rtl/dense_mac_requant_engine.sv
// rtl/dense_mac_requant_engine.sv - zero-point int8 dot product, bias, ReLU and int8 requantization
// One output neuron per job; products come from an external combinational multiplier.
module dense_mac_requant_engine #(
  parameter int LEN_W = 10,
  parameter int ACC_W = 32
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_start,
  input  logic [LEN_W-1:0]        i_vec_len,
  input  logic signed [7:0]       i_input_zp,
  input  logic signed [7:0]       i_filter_zp,
  input  logic signed [7:0]       i_output_zp,
  input  logic signed [31:0]      i_bias,
  input  logic signed [31:0]      i_quant_mult,
  input  logic signed [31:0]      i_quant_shift,
  input  logic                    i_relu_bypass,
  input  logic                    i_valid,
  output logic                    o_ready,
  input  logic signed [7:0]       i_x,
  input  logic signed [7:0]       i_w,
  output logic signed [15:0]      o_mul_a,
  output logic signed [15:0]      o_mul_b,
  input  logic signed [ACC_W-1:0] i_mul_z,
  output logic                    o_valid,
  input  logic                    i_ready,
  output logic [7:0]              o_y,
  output logic                    o_busy
);

  typedef enum logic [2:0] {S_IDLE, S_MAC, S_BIAS, S_REQ, S_OUT} state_t;

  state_t                  r_state;
  state_t                  w_next;
  logic [LEN_W-1:0]        r_len;
  logic [LEN_W-1:0]        r_cnt;
  logic signed [7:0]       r_input_zp;
  logic signed [7:0]       r_filter_zp;
  logic signed [7:0]       r_output_zp;
  logic signed [31:0]      r_bias;
  logic signed [31:0]      r_quant_mult;
  logic [6:0]              r_total_shift;
  logic                    r_relu_bypass;
  logic signed [ACC_W-1:0] r_acc;
  logic [7:0]              r_y;

  logic                    w_accept;
  logic                    w_last_beat;
  logic signed [ACC_W-1:0] w_biased;
  logic signed [63:0]      w_acc64;
  logic signed [63:0]      w_mult64;
  logic signed [63:0]      w_round;
  logic signed [63:0]      w_p64;
  logic signed [63:0]      w_s64;
  logic [15:0]             w_sum16;
  logic                    w_unused;

  assign o_mul_a = 16'($signed(i_x)) - 16'($signed(r_input_zp));
  assign o_mul_b = 16'($signed(i_w)) - 16'($signed(r_filter_zp));

  assign w_accept    = i_valid && (r_state == S_MAC);
  assign w_last_beat = (r_cnt == r_len - LEN_W'(1));
  assign w_biased    = r_acc + r_bias;

  // Sign-extend both operands to 64 bits so the low 64 product bits are the exact signed product.
  assign w_acc64  = {{(64-ACC_W){r_acc[ACC_W-1]}}, r_acc};
  assign w_mult64 = {{32{r_quant_mult[31]}}, r_quant_mult};
  assign w_round  = 64'sd1 <<< (r_total_shift - 7'd1);
  assign w_p64    = (w_acc64 * w_mult64) + w_round;
  assign w_s64    = w_p64 >>> r_total_shift;
  assign w_sum16  = w_s64[15:0] + {{8{r_output_zp[7]}}, r_output_zp};
  assign w_unused = ^{w_s64[63:16], w_sum16[15:8], i_quant_shift[31:7]};

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next  = r_state;
    o_ready = 1'b0;
    o_valid = 1'b0;
    o_busy  = 1'b1;
    case (r_state)
      S_IDLE: begin
        o_busy = 1'b0;
        if (i_start) begin
          w_next = (i_vec_len == '0) ? S_BIAS : S_MAC;
        end
      end
      S_MAC: begin
        o_ready = 1'b1;
        if (w_accept && w_last_beat) begin
          w_next = S_BIAS;
        end
      end
      S_BIAS: w_next = S_REQ;
      S_REQ:  w_next = S_OUT;
      S_OUT: begin
        o_valid = 1'b1;
        if (i_ready) begin
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_len         <= '0;
      r_cnt         <= '0;
      r_input_zp    <= '0;
      r_filter_zp   <= '0;
      r_output_zp   <= '0;
      r_bias        <= '0;
      r_quant_mult  <= '0;
      r_total_shift <= '0;
      r_relu_bypass <= 1'b0;
      r_acc         <= '0;
      r_y           <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_len         <= i_vec_len;
            r_cnt         <= '0;
            r_input_zp    <= i_input_zp;
            r_filter_zp   <= i_filter_zp;
            r_output_zp   <= i_output_zp;
            r_bias        <= i_bias;
            r_quant_mult  <= i_quant_mult;
            r_total_shift <= 7'd31 - i_quant_shift[6:0];
            r_relu_bypass <= i_relu_bypass;
            r_acc         <= '0;
          end
        end
        S_MAC: begin
          if (w_accept) begin
            r_acc <= r_acc + i_mul_z;
            r_cnt <= r_cnt + LEN_W'(1);
          end
        end
        // ReLU is folded into the bias step so REQ sees the clamped value directly.
        S_BIAS: begin
          r_acc <= (!r_relu_bypass && w_biased[ACC_W-1]) ? '0 : w_biased;
        end
        S_REQ: begin
          r_y <= w_sum16[7:0];
        end
        default: ;
      endcase
    end
  end

  assign o_y = r_y;

endmodule

// File: tb/tb_dense_mac_requant_engine.sv
// tb/tb_dense_mac_requant_engine.sv - directed and randomized checks against a behavioural neuron model
module tb_dense_mac_requant_engine;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               i_start;
  logic [9:0]         i_vec_len;
  logic signed [7:0]  i_input_zp, i_filter_zp, i_output_zp;
  logic signed [31:0] i_bias, i_quant_mult, i_quant_shift;
  logic               i_relu_bypass;
  logic               i_valid;
  logic               o_ready;
  logic signed [7:0]  i_x, i_w;
  logic signed [15:0] o_mul_a, o_mul_b;
  logic signed [31:0] mul_z;
  logic               o_valid;
  logic               i_ready;
  logic [7:0]         o_y;
  logic               o_busy;

  int  checks = 0;
  int  failures = 0;
  byte xv[1024];
  byte wv[1024];

  always #5 clk = ~clk;

  assign mul_z = $signed(o_mul_a) * $signed(o_mul_b);

  dense_mac_requant_engine #(.LEN_W(10), .ACC_W(32)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(i_start), .i_vec_len(i_vec_len),
    .i_input_zp(i_input_zp), .i_filter_zp(i_filter_zp), .i_output_zp(i_output_zp),
    .i_bias(i_bias), .i_quant_mult(i_quant_mult), .i_quant_shift(i_quant_shift),
    .i_relu_bypass(i_relu_bypass), .i_valid(i_valid), .o_ready(o_ready),
    .i_x(i_x), .i_w(i_w), .o_mul_a(o_mul_a), .o_mul_b(o_mul_b), .i_mul_z(mul_z),
    .o_valid(o_valid), .i_ready(i_ready), .o_y(o_y), .o_busy(o_busy)
  );

  task automatic check(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] model(input int len, input int izp, input int fzp, input int ozp,
                                       input int bias, input int mult, input int shift, input bit bypass);
    int     acc;
    int     ts;
    longint p;
    longint s;
    acc = 0;
    for (int i = 0; i < len; i++) acc += (int'(xv[i]) - izp) * (int'(wv[i]) - fzp);
    acc += bias;
    if (!bypass && acc < 0) acc = 0;
    ts = 31 - shift;
    p = longint'(acc) * longint'(mult) + (longint'(1) << (ts - 1));
    s = p >>> ts;
    return 8'(s + longint'(ozp));
  endfunction

  task automatic start_job(input int len, input int izp, input int fzp, input int ozp,
                           input int bias, input int mult, input int shift, input bit bypass);
    i_vec_len = 10'(len);
    i_input_zp = 8'(izp);
    i_filter_zp = 8'(fzp);
    i_output_zp = 8'(ozp);
    i_bias = bias;
    i_quant_mult = mult;
    i_quant_shift = shift;
    i_relu_bypass = bypass;
    i_start = 1'b1;
    step();
    i_start = 1'b0;
  endtask

  // Valid pattern bit c drives cycle c; beyond the pattern, valid is random or held high.
  task automatic feed(input int len, input logic [31:0] pat, input int patlen, input bit rnd,
                      output int accepted, output int cycles);
    int  idx;
    int  c;
    bit  acc;
    idx = 0;
    c = 0;
    while (idx < len && c < 8000) begin
      i_valid = (c < patlen) ? pat[c] : (rnd ? 1'($urandom_range(0, 1)) : 1'b1);
      i_x = xv[idx];
      i_w = wv[idx];
      acc = i_valid && o_ready;
      step();
      if (acc) idx++;
      c++;
    end
    i_valid = 1'b0;
    accepted = idx;
    cycles = c;
  endtask

  task automatic get_result(input string tag, input logic [7:0] exp, input int hold);
    int lat;
    logic [7:0] y0;
    lat = 0;
    while (!o_valid && lat < 20) begin
      step();
      lat++;
    end
    check({tag, "_latency"}, lat, 2);
    check({tag, "_y"}, o_y, exp);
    y0 = o_y;
    for (int h = 0; h < hold; h++) begin
      i_start = (h % 2 == 0);
      i_vec_len = 10'd0;
      i_bias = 32'sd1000;
      step();
      i_start = 1'b0;
      check({tag, "_hold_valid"}, o_valid, 1);
      check({tag, "_hold_y"}, o_y, y0);
    end
    i_ready = 1'b1;
    step();
    i_ready = 1'b0;
    check({tag, "_valid_drop"}, o_valid, 0);
    check({tag, "_idle"}, o_busy, 0);
  endtask

  initial begin
    int acc_n;
    int cyc;
    int izp, fzp, ozp, bias, mult, shift;
    bit byp;
    logic [7:0] exp;

    rst_n = 1'b0;
    i_start = 0; i_vec_len = 0; i_input_zp = 0; i_filter_zp = 0; i_output_zp = 0;
    i_bias = 0; i_quant_mult = 0; i_quant_shift = 0; i_relu_bypass = 0;
    i_valid = 0; i_x = 0; i_w = 0; i_ready = 0;
    step();
    step();
    check("rst_ready", o_ready, 0);
    check("rst_valid", o_valid, 0);
    check("rst_y", o_y, 0);
    check("rst_busy", o_busy, 0);
    rst_n = 1'b1;
    step();

    // Basic len=1 job
    xv[0] = 10; wv[0] = 3;
    start_job(1, 0, 0, 0, 0, 32'h40000000, 0, 0);
    check("basic_busy", o_busy, 1);
    check("basic_ready", o_ready, 1);
    feed(1, 0, 0, 0, acc_n, cyc);
    get_result("basic", 8'h0F, 0);

    // ReLU clamp, then linear mode with a negative pre-activation
    xv[0] = -10; wv[0] = 3;
    start_job(1, 0, 0, -128, 0, 32'h40000000, 0, 0);
    feed(1, 0, 0, 0, acc_n, cyc);
    get_result("relu_clamp", 8'h80, 0);
    start_job(1, 0, 0, 0, 0, 32'h40000000, 0, 1);
    feed(1, 0, 0, 0, acc_n, cyc);
    get_result("relu_bypass", 8'hF1, 0);

    // Zero-point correction on the multiplier port
    xv[0] = 5; wv[0] = 2;
    start_job(1, -128, 0, -128, 0, 32'h40000000, 0, 0);
    i_x = 5; i_w = 2;
    #1;
    check("zp_mul_a", o_mul_a, 133);
    check("zp_mul_b", o_mul_b, 2);
    feed(1, 0, 0, 0, acc_n, cyc);
    get_result("zp", 8'h05, 0);

    // Backpressure on operands and on the result
    for (int i = 0; i < 4; i++) begin xv[i] = 1; wv[i] = 1; end
    start_job(4, 0, 0, 0, 6, 32'h40000000, 0, 0);
    feed(4, 32'b1011001, 7, 0, acc_n, cyc);
    check("bp_beats", acc_n, 4);
    check("bp_cycles", cyc, 7);
    get_result("bp", 8'h05, 5);
    start_job(0, 0, 0, 0, 6, 32'h40000000, 0, 0);
    get_result("len0", 8'h03, 0);

    // Reset mid-MAC, then a fresh job
    for (int i = 0; i < 4; i++) begin xv[i] = 7; wv[i] = 9; end
    start_job(4, 0, 0, 0, 0, 32'h40000000, 0, 0);
    feed(2, 0, 0, 0, acc_n, cyc);
    check("mid_busy", o_busy, 1);
    rst_n = 1'b0;
    #1;
    check("midrst_ready", o_ready, 0);
    check("midrst_valid", o_valid, 0);
    check("midrst_y", o_y, 0);
    check("midrst_busy", o_busy, 0);
    step();
    rst_n = 1'b1;
    step();
    for (int i = 0; i < 4; i++) begin xv[i] = 1; wv[i] = 1; end
    start_job(4, 0, 0, 0, 6, 32'h40000000, 0, 0);
    feed(4, 0, 0, 0, acc_n, cyc);
    get_result("post_rst", 8'h05, 0);

    // Randomized 784-beat neurons with random stalls
    for (int n = 0; n < 10; n++) begin
      for (int i = 0; i < 784; i++) begin
        xv[i] = byte'($urandom);
        wv[i] = byte'($urandom);
      end
      izp = $urandom_range(0, 255) - 128;
      fzp = $urandom_range(0, 255) - 128;
      ozp = $urandom_range(0, 255) - 128;
      bias = int'($urandom_range(0, 2000000)) - 1000000;
      mult = int'($urandom_range(32'h20000000, 32'h7FFFFFFF));
      shift = (n < 5) ? int'($urandom_range(0, 30)) - 20 : int'($urandom_range(0, 61)) - 31;
      byp = 1'($urandom_range(0, 1));
      exp = model(784, izp, fzp, ozp, bias, mult, shift, byp);
      start_job(784, izp, fzp, ozp, bias, mult, shift, byp);
      feed(784, 0, 0, 1, acc_n, cyc);
      check("rand_beats", acc_n, 784);
      get_result("rand", exp, n % 3);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
